div_unit: RTL and testbench

//  Multi-cycle radix-2 integer divider for DIV/DIVU in the execute stage, beside the ALU.

---
 rtl/div_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_div_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Produces quotient on lo_o and remainder on hi_o. It holds the pipeline
// through stall_o while it iterates, one quotient bit per cycle.
// Signed operands are divided as magnitudes, and the signs are fixed up
// on the edge that enters DONE.

module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_div,
  input  logic             start,
  input  logic             annul,
  input  logic             hold,
  output logic             stall_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Two's complement negation, wrapping modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] x);
    return (~x) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of x when treated as signed; raw value otherwise.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic             is_signed);
    logic [WIDTH-1:0] m;
    if (is_signed && x[WIDTH-1]) begin
      m = twos_neg(x);
    end else begin
      m = x;
    end
    return m;
  endfunction

  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvsr_r;
  logic             neg_quo_r;
  logic             neg_rem_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             ready_r;
  logic             dbz_r;

  logic             launch_s;
  logic             b_zero_s;
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH+1:0] trial_s;
  logic             trial_neg_s;
  logic [WIDTH-1:0] rem_step_s;
  logic [WIDTH-1:0] quo_step_s;
  logic             stall_s;

  assign launch_s = start & ~annul;
  assign b_zero_s = (b == ZERO_W);

  // One restoring step: shift {rem,quo} left and trial-subtract the divisor.
  always_comb begin
    rem_sh_s    = {rem_r, quo_r[WIDTH-1]};
    trial_s     = {1'b0, rem_sh_s} - {2'b00, dvsr_r};
    trial_neg_s = trial_s[WIDTH+1];
    if (trial_neg_s) begin
      rem_step_s = rem_sh_s[WIDTH-1:0];
    end else begin
      rem_step_s = trial_s[WIDTH-1:0];
    end
    quo_step_s = {quo_r[WIDTH-2:0], ~trial_neg_s};
  end

  // Next-state selection; annul overrides start and hold in every state.
  always_comb begin
    next_state_s = state_r;
    if (annul) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if (b_zero_s) begin
              next_state_s = ST_DONE;
            end else begin
              next_state_s = ST_BUSY;
            end
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (cnt_r == CNT_LAST) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_BUSY;
          end
        end
        ST_DONE: begin
          if (hold) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        default: next_state_s = ST_IDLE;
      endcase
    end
  end

  // Pipeline freeze request; must read 0 while reset is asserted.
  always_comb begin
    stall_s = 1'b0;
    if (rst) begin
      stall_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: stall_s = launch_s;
        ST_BUSY: stall_s = ~annul;
        ST_DONE: stall_s = 1'b0;
        default: stall_s = 1'b0;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Datapath: operand capture, iteration and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= CNT_ZERO;
      rem_r     <= ZERO_W;
      quo_r     <= ZERO_W;
      dvsr_r    <= ZERO_W;
      neg_quo_r <= 1'b0;
      neg_rem_r <= 1'b0;
      hi_r      <= ZERO_W;
      lo_r      <= ZERO_W;
      dbz_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (launch_s) begin
            dvsr_r    <= magnitude(b, signed_div);
            quo_r     <= magnitude(a, signed_div);
            rem_r     <= ZERO_W;
            cnt_r     <= CNT_ZERO;
            neg_quo_r <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_r <= signed_div & a[WIDTH-1];
            if (b_zero_s) begin
              // Divide by zero: quotient saturates, remainder is the dividend.
              hi_r  <= a;
              lo_r  <= ONES_W;
              dbz_r <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          if (!annul) begin
            rem_r <= rem_step_s;
            quo_r <= quo_step_s;
            cnt_r <= cnt_r + CNT_ONE;
            if (cnt_r == CNT_LAST) begin
              // Final step: apply sign correction while registering results.
              lo_r  <= neg_quo_r ? twos_neg(quo_step_s) : quo_step_s;
              hi_r  <= neg_rem_r ? twos_neg(rem_step_s) : rem_step_s;
              dbz_r <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= CNT_ZERO;
        end
      endcase
    end
  end

  // Registered result strobe, high exactly while in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_r <= 1'b0;
    end else begin
      ready_r <= (next_state_s == ST_DONE);
    end
  end

  assign stall_o     = stall_s;
  assign ready_o     = ready_r;
  assign hi_o        = hi_r;
  assign lo_o        = lo_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed table, hand-written corner sequences and random
// divides compared against an arithmetic reference model.

module tb_div_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         signed_div;
  logic         start;
  logic         annul;
  logic         hold;
  logic         stall_o;
  logic         ready_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .signed_div(signed_div),
    .start(start), .annul(annul), .hold(hold), .stall_o(stall_o),
    .ready_o(ready_o), .hi_o(hi_o), .lo_o(lo_o), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sg;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dbz;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: quotient truncates toward zero, remainder takes dividend's sign.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                input logic sg, output logic [W-1:0] lo,
                                output logic [W-1:0] hi, output logic dbz);
    int sa;
    int sb;
    dbz = 1'b0;
    if (mb == 32'd0) begin
      lo  = 32'hFFFF_FFFF;
      hi  = ma;
      dbz = 1'b1;
    end else if (!sg) begin
      lo = ma / mb;
      hi = ma % mb;
    end else if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
      lo = 32'h8000_0000;
      hi = 32'd0;
    end else begin
      sa = ma;
      sb = mb;
      lo = sa / sb;
      hi = sa % sb;
    end
  endfunction

  // Wait (bounded) for ready_o; stall_ok drops if stall_o ever fell early.
  task automatic wait_ready(output int lat, output logic stall_ok);
    lat      = 0;
    stall_ok = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ready_o === 1'b1) begin
        lat = n;
        return;
      end
      if (stall_o !== 1'b1) stall_ok = 1'b0;
    end
  endtask

  task automatic run_div(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic sg, input logic [W-1:0] elo, input logic [W-1:0] ehi,
                         input logic edbz);
    int   lat;
    logic sok;
    @(negedge clk);
    a = ia; b = ib; signed_div = sg; start = 1'b1;
    #1;
    chk({name, " stall_c0"}, {31'd0, stall_o}, 32'd1);
    wait_ready(lat, sok);
    start = 1'b0;
    #1;
    chk({name, " latency"}, lat, (ib == 32'd0) ? 32'd1 : 32'd33);
    chk({name, " stall_held"}, {31'd0, sok}, 32'd1);
    chk({name, " lo"}, lo_o, elo);
    chk({name, " hi"}, hi_o, ehi);
    chk({name, " dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
    chk({name, " stall_done"}, {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    chk({name, " ready_drop"}, {31'd0, ready_o}, 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    int           lat;
    logic         sok;
    logic         seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    logic [W-1:0] elo;
    logic [W-1:0] ehi;
    logic         edbz;

    vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
    vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    vecs[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0};
    vecs[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0};
    vecs[4] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[5] = '{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b1};
    vecs[6] = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF,  1'b0};

    // Reset state, with start high to show stall is forced low.
    rst = 1'b1; a = 32'd5; b = 32'd0; signed_div = 1'b0;
    start = 1'b1; annul = 1'b0; hold = 1'b0;
    #3;
    chk("rst stall", {31'd0, stall_o}, 32'd0);
    chk("rst ready", {31'd0, ready_o}, 32'd0);
    chk("rst lo", lo_o, 32'd0);
    chk("rst hi", hi_o, 32'd0);
    chk("rst dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sg,
              vecs[i].lo, vecs[i].hi, vecs[i].dbz);
    end

    // Annul in BUSY cycle 10; old results (from 5/0) must survive.
    run_div("pre_annul", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    @(negedge clk);
    a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
    for (int n = 1; n <= 10; n++) @(negedge clk);
    annul = 1'b1;
    #1;
    chk("annul stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    chk("annul ready", {31'd0, ready_o}, 32'd0);
    annul = 1'b0; start = 1'b0;
    #1;
    chk("annul idle stall", {31'd0, stall_o}, 32'd0);
    chk("annul lo kept", lo_o, 32'hFFFF_FFFF);
    chk("annul hi kept", hi_o, 32'd5);
    chk("annul dbz kept", {31'd0, div_by_zero}, 32'd1);
    seen = 1'b0;
    for (int n = 0; n < 35; n++) begin
      @(negedge clk);
      if (ready_o === 1'b1) seen = 1'b1;
    end
    chk("annul no result", {31'd0, seen}, 32'd0);
    run_div("post_annul", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);

    // Hold in DONE for 3 cycles: ready and results stable for 4 cycles.
    @(negedge clk);
    a = 32'd1000; b = 32'd10; signed_div = 1'b0; start = 1'b1;
    wait_ready(lat, sok);
    start = 1'b0; hold = 1'b1;
    chk("hold lat", lat, 32'd33);
    chk("hold lo0", lo_o, 32'd100);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("hold ready%0d", k), {31'd0, ready_o}, 32'd1);
      chk($sformatf("hold lo%0d", k + 1), lo_o, 32'd100);
      chk($sformatf("hold hi%0d", k + 1), hi_o, 32'd0);
      if (k == 2) hold = 1'b0;
    end
    @(negedge clk);
    chk("hold release", {31'd0, ready_o}, 32'd0);

    // Annul wins over hold in DONE.
    @(negedge clk);
    a = 32'd8; b = 32'd0; start = 1'b1;
    wait_ready(lat, sok);
    start = 1'b0; hold = 1'b1; annul = 1'b1;
    @(negedge clk);
    chk("annul over hold", {31'd0, ready_o}, 32'd0);
    annul = 1'b0; hold = 1'b0;

    // Back-to-back with start held across DONE.
    @(negedge clk);
    a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
    wait_ready(lat, sok);
    chk("b2b first lo", lo_o, 32'd14);
    a = 32'd9; b = 32'd3;
    @(negedge clk);
    chk("b2b idle ready", {31'd0, ready_o}, 32'd0);
    chk("b2b idle stall", {31'd0, stall_o}, 32'd1);
    wait_ready(lat, sok);
    start = 1'b0;
    chk("b2b lat", lat, 32'd33);
    chk("b2b lo", lo_o, 32'd3);
    chk("b2b hi", hi_o, 32'd0);
    @(negedge clk);

    // Reset pulse mid-BUSY clears outputs asynchronously.
    run_div("pre_rst", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    @(negedge clk);
    a = 32'd77; b = 32'd5; start = 1'b1;
    for (int n = 0; n < 15; n++) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst lo", lo_o, 32'd0);
    chk("midrst hi", hi_o, 32'd0);
    chk("midrst stall", {31'd0, stall_o}, 32'd0);
    chk("midrst ready", {31'd0, ready_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    run_div("post_rst", 32'd77, 32'd5, 1'b0, 32'd15, 32'd2, 1'b0);

    // Random divides against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1, 2, 3: rb = 32'($urandom_range(1, 15));
        4:       begin rb = 32'hFFFF_FFFF; ra = 32'h8000_0000; end
        default: rb = $urandom;
      endcase
      if (rs && rb != 32'd0 && $urandom_range(0, 1) == 1) rb = -rb;
      model(ra, rb, rs, elo, ehi, edbz);
      run_div($sformatf("rnd%0d", i), ra, rb, rs, elo, ehi, edbz);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
